// File: rtl/mealey_stimulus_gen.sv
// Burst stimulus source for the Mealey top entity: ramp (default) or 9-bit LFSR
// samples with a running signed sum. LFSR build selected by MEALEY_STIM_LFSR_EN.
module mealey_stimulus_gen #(
  parameter int unsigned SAMPLE_W    = 9,
  parameter int unsigned NUM_SAMPLES = 16,
  parameter int          START_VAL   = -4,
  parameter int          STEP        = 1,
  parameter int unsigned SEED        = 1,
  parameter int unsigned SUM_W       = 16
) (
  input  logic                system1000,
  input  logic                system1000_rstn,
  input  logic                start,
  input  logic                hold,
  output logic [SAMPLE_W-1:0] eta_o,
  output logic                eta_vld,
  output logic                busy,
  output logic                done,
  output logic [SUM_W-1:0]    sum_o
);

  localparam int unsigned CNT_W = (NUM_SAMPLES < 2) ? 1 : $clog2(NUM_SAMPLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SAMPLES);

`ifdef MEALEY_STIM_LFSR_EN
  // Seed of zero would lock the LFSR, so it is forced to one.
  localparam logic [SAMPLE_W-1:0] FIRST = (SEED == 0) ? SAMPLE_W'(1) : SAMPLE_W'(SEED);

  function automatic logic [SAMPLE_W-1:0] next_sample(input logic [SAMPLE_W-1:0] s);
    return {s[7:0], s[8] ^ s[4]};
  endfunction
`else
  localparam logic [SAMPLE_W-1:0] FIRST  = SAMPLE_W'(START_VAL);
  localparam logic [SAMPLE_W-1:0] STEP_V = SAMPLE_W'(STEP);

  function automatic logic [SAMPLE_W-1:0] next_sample(input logic [SAMPLE_W-1:0] s);
    return s + STEP_V;
  endfunction
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [SAMPLE_W-1:0] eta_d;
  logic                vld_d, busy_d, done_d;
  logic [SUM_W-1:0]    sum_d;

  // State and all outputs registered together.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      eta_o   <= '0;
      eta_vld <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum_o   <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      eta_o   <= eta_d;
      eta_vld <= vld_d;
      busy    <= busy_d;
      done    <= done_d;
      sum_o   <= sum_d;
    end
  end

  // Next state; the sum absorbs the sample registered on the previous edge.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    eta_d   = eta_o;
    vld_d   = 1'b0;
    busy_d  = busy;
    done_d  = done;
    sum_d   = sum_o;
    if (eta_vld) begin
      sum_d = sum_o + SUM_W'($signed(eta_o));
    end
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          sum_d = '0;
          if (NUM_SAMPLES == 0) begin
            state_d = S_DONE;
            eta_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = S_RUN;
            eta_d   = FIRST;
            vld_d   = 1'b1;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      S_RUN: begin
        if (!hold) begin
          if (cnt == CNT_LAST) begin
            state_d = S_DONE;
            eta_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            eta_d   = next_sample(eta_o);
            vld_d   = 1'b1;
            cnt_d   = cnt + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
